// File: rtl/adder_arb_pkg.sv
// Shared types and widths for the round-robin arbiter in front of the shared adder.
package adder_arb_pkg;

  localparam int ADD_W  = 16;
  localparam int WIDE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } arb_state_t;

  // Round-robin successor of a requester index
  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Carry-lookahead adder built from 4-bit groups with group generate/propagate
// terms feeding the group carries.
module carry_lookahead_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int GRP = 4;
  localparam int NG  = WIDTH / GRP;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG-1:0]    cg;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      assign gp[gi] = &p[GRP*gi +: GRP];
      assign gg[gi] = g[GRP*gi+3]
                    | (p[GRP*gi+3] & g[GRP*gi+2])
                    | (p[GRP*gi+3] & p[GRP*gi+2] & g[GRP*gi+1])
                    | (p[GRP*gi+3] & p[GRP*gi+2] & p[GRP*gi+1] & g[GRP*gi]);
    end
  endgenerate

  always_comb begin
    cg = '0;
    c  = '0;
    cg[0] = cin;
    for (int i = 1; i < NG; i++) begin
      cg[i] = gg[i-1] | (gp[i-1] & cg[i-1]);
    end
    c[0] = cg[0];
    // Bit carries ripple only inside a group; group boundaries take the lookahead carry
    for (int i = 1; i < WIDTH; i++) begin
      c[i] = (i % GRP == 0) ? cg[i/GRP] : (g[i-1] | (p[i-1] & c[i-1]));
    end
  end

  assign sum  = p ^ c;
  assign cout = gg[NG-1] | (gp[NG-1] & cg[NG-1]);

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            found
);

  logic [2*N-1:0] rot;
  int             off;
  int             pos;

  always_comb begin
    // Rotating the doubled vector puts requester (ptr+i) mod N at bit i
    rot   = {valid, valid} >> ptr;
    found = 1'b0;
    off   = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    pos = int'(ptr) + off;
    if (pos >= N) begin
      pos = pos - N;
    end
    grant_id = ID_W'(pos);
    grant    = found ? (N'(1) << grant_id) : '0;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 16-bit adder among NUM_REQ requesters;
// 32-bit adds take two passes with the inter-half carry held in c16_reg.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*WIDE_W-1:0] req_a,
  input  logic [NUM_REQ*WIDE_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  input  logic [NUM_REQ-1:0]        req_wide,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [WIDE_W-1:0]         rsp_sum,
  output logic                      rsp_cout
);

  arb_state_t        state_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [WIDE_W-1:0] a_reg;
  logic [WIDE_W-1:0] b_reg;
  logic              cin_reg;
  logic              wide_reg;
  logic              c16_reg;
  logic              rsp_valid_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [WIDE_W-1:0] rsp_sum_reg;
  logic              rsp_cout_reg;

  logic [WIDE_W-1:0] a_lane [NUM_REQ];
  logic [WIDE_W-1:0] b_lane [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign a_lane[gi] = req_a[WIDE_W*gi +: WIDE_W];
      assign b_lane[gi] = req_b[WIDE_W*gi +: WIDE_W];
    end
  endgenerate

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_id;
  logic               pick_found;

  rr_picker #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .valid    (req_valid),
    .ptr      (rr_ptr_reg),
    .grant    (pick_grant),
    .grant_id (pick_id),
    .found    (pick_found)
  );

  // Gated by rst_n so the accept drops the moment reset is asserted
  assign req_ready = (rst_n && state_reg == IDLE) ? pick_grant : '0;

  logic [ADD_W-1:0] add_a;
  logic [ADD_W-1:0] add_b;
  logic             add_cin;
  logic [ADD_W-1:0] add_sum;
  logic             add_cout;

  always_comb begin
    add_a   = a_reg[ADD_W-1:0];
    add_b   = b_reg[ADD_W-1:0];
    add_cin = cin_reg;
    if (state_reg == HI) begin
      add_a   = a_reg[WIDE_W-1:ADD_W];
      add_b   = b_reg[WIDE_W-1:ADD_W];
      add_cin = c16_reg;
    end
  end

  carry_lookahead_adder #(
    .WIDTH (ADD_W)
  ) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      cin_reg       <= 1'b0;
      wide_reg      <= 1'b0;
      c16_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_sum_reg   <= '0;
      rsp_cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            a_reg      <= a_lane[pick_id];
            b_reg      <= b_lane[pick_id];
            cin_reg    <= req_cin[pick_id];
            wide_reg   <= req_wide[pick_id];
            rsp_id_reg <= pick_id;
            state_reg  <= LO;
          end
        end
        LO: begin
          // Upper half cleared here so a narrow result reads back zero-extended
          rsp_sum_reg  <= {{(WIDE_W-ADD_W){1'b0}}, add_sum};
          c16_reg      <= add_cout;
          rsp_cout_reg <= add_cout;
          if (wide_reg) begin
            state_reg <= HI;
          end else begin
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        HI: begin
          rsp_sum_reg[WIDE_W-1:ADD_W] <= add_sum;
          rsp_cout_reg                <= add_cout;
          rsp_valid_reg               <= 1'b1;
          state_reg                   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rr_ptr_reg    <= ID_W'(rr_next(int'(rsp_id_reg), NUM_REQ));
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_cout  = rsp_cout_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and randomized checks of adder_arbiter against an arithmetic
// reference model with a round-robin pointer kept as a plain integer.
module tb_adder_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]  req_cin;
  logic [N-1:0]  req_wide;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [IW-1:0] rsp_id;
  logic [31:0]   rsp_sum;
  logic          rsp_cout;

  adder_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_wide  (req_wide),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          ptr_m       = 0;
  logic [31:0] a_m   [N];
  logic [31:0] b_m   [N];
  logic        cin_m [N];
  logic        wide_m[N];
  logic [N-1:0] vmask;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = a_m[i];
      req_b[32*i +: 32] = b_m[i];
      req_cin[i]        = cin_m[i];
      req_wide[i]       = wide_m[i];
    end
    req_valid = vmask;
  endtask

  task automatic rand_op(input int i);
    a_m[i]    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
    b_m[i]    = 32'($urandom);
    cin_m[i]  = 1'($urandom_range(0, 1));
    wide_m[i] = 1'($urandom_range(0, 1));
  endtask

  function automatic int pick_m(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // {cout, sum}: full 33-bit add when wide, else 17-bit add of the low halves
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic wide);
    logic [32:0] w;
    logic [16:0] n;
    w = {1'b0, a} + {1'b0, b} + 33'(cin);
    n = {1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(cin);
    return wide ? w : {n[16], 16'h0000, n[15:0]};
  endfunction

  // Grant, latency, response and handshake for one transaction
  task automatic serve(input int stall, input bit refill);
    int          cyc;
    int          exp_id;
    int          lat;
    logic [32:0] exp;
    drive();
    #1;
    cyc = 0;
    while (req_ready == '0 && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (req_ready == '0) begin
      vectors++;
      miscompares++;
      $error("FAIL grant_timeout: observed req_ready %0h expected a grant", req_ready);
      return;
    end
    exp_id = pick_m(vmask, ptr_m);
    check("ready_onehot", 64'($countones(req_ready)), 64'd1);
    check("grant", 64'(req_ready), 64'(1) << exp_id);
    exp = ref_add(a_m[exp_id], b_m[exp_id], cin_m[exp_id], wide_m[exp_id]);
    lat = wide_m[exp_id] ? 3 : 2;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (refill) rand_op(exp_id);
        else vmask[exp_id] = 1'b0;
        drive();
      end
      #1;
      check("rsp_valid_timing", 64'(rsp_valid), 64'(k == lat));
      check("ready_busy", 64'(req_ready), 64'd0);
    end
    check("rsp_id", 64'(rsp_id), 64'(exp_id));
    check("rsp_sum", 64'(rsp_sum), 64'(exp[31:0]));
    check("rsp_cout", 64'(rsp_cout), 64'(exp[32]));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_ready", 64'(req_ready), 64'd0);
      check("stall_fields", {29'd0, rsp_cout, rsp_id, rsp_sum},
            {29'd0, exp[32], IW'(exp_id), exp[31:0]});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_done", 64'(rsp_valid), 64'd0);
    ptr_m = (exp_id + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_m[i] = '0; b_m[i] = '0; cin_m[i] = 1'b0; wide_m[i] = 1'b0;
    end
    vmask = 4'b1111;
    drive();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_sum", 64'(rsp_sum), 64'd0);
    check("rst_cout", 64'(rsp_cout), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vmask = '0;
    drive();

    // Narrow add, carry out of bit 15
    a_m[0] = 32'h0000_FFFF; b_m[0] = 32'h0000_0001; cin_m[0] = 1'b0; wide_m[0] = 1'b0;
    vmask = 4'b0001;
    serve(0, 1'b0);
    check("narrow_sum_lit", 64'(rsp_sum), 64'h0);
    check("narrow_cout_lit", 64'(rsp_cout), 64'd1);

    // Wide add, carry crosses the half boundary
    a_m[2] = 32'h0001_FFFF; b_m[2] = 32'h0000_0001; cin_m[2] = 1'b1; wide_m[2] = 1'b1;
    vmask = 4'b0100;
    serve(0, 1'b0);
    check("wide_sum_lit", 64'(rsp_sum), 64'h0002_0001);
    check("wide_cout_lit", 64'(rsp_cout), 64'd0);

    // Wide overflow
    a_m[3] = 32'hFFFF_FFFF; b_m[3] = 32'h0; cin_m[3] = 1'b1; wide_m[3] = 1'b1;
    vmask = 4'b1000;
    serve(0, 1'b0);
    check("ovf_sum_lit", 64'(rsp_sum), 64'h0);
    check("ovf_cout_lit", 64'(rsp_cout), 64'd1);

    // Fairness with all four requesters continuously valid
    for (int i = 0; i < N; i++) rand_op(i);
    vmask = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      serve(0, 1'b1);
      check("rr_order", 64'(rsp_id), 64'(t % N));
    end
    vmask = '0;
    drive();
    repeat (3) @(negedge clk);

    // Backpressure
    rand_op(1);
    vmask = 4'b0010;
    serve(10, 1'b0);

    // Reset during the HI pass of a wide op from requester 3
    rand_op(3);
    wide_m[3] = 1'b1;
    vmask = 4'b1000;
    drive();
    #1;
    check("rst_op_grant", 64'(req_ready), 64'b1000);
    @(negedge clk);
    vmask = '0;
    drive();
    @(negedge clk);
    rand_op(1);
    vmask = 4'b0011 & 4'b0010;
    rst_n = 1'b0;
    drive();
    #1;
    check("midrst_valid", 64'(rsp_valid), 64'd0);
    check("midrst_id", 64'(rsp_id), 64'd0);
    check("midrst_sum", 64'(rsp_sum), 64'd0);
    check("midrst_cout", 64'(rsp_cout), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    rst_n = 1'b1;
    ptr_m = 0;
    serve(0, 1'b0);
    check("post_rst_id", 64'(rsp_id), 64'd1);

    // Randomized traffic with occasional backpressure
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!vmask[i] && $urandom_range(0, 1) == 1) begin
          rand_op(i);
          vmask[i] = 1'b1;
        end
      end
      if (vmask == '0) begin
        int r;
        r = $urandom_range(0, N - 1);
        rand_op(r);
        vmask[r] = 1'b1;
      end
      serve(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one 16-bit `carry_lookahead_adder` between `NUM_REQ` requesters using round-robin arbitration. Each requester issues either a 16-bit add or a 32-bit add; a 32-bit add is executed as two sequential passes through the adder, with the carry registered between passes. The block sits between the DSP accumulation/filter front-ends and the shared adder datapath, and returns each result tagged with the requester ID over a single response channel.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  Per-requester request valid.
- `req_ready`  out  NUM_REQ  Per-requester accept. One-hot or zero.
- `req_a`  in  NUM_REQ*32  Operand A; requester i occupies bits [32i+31:32i].
- `req_b`  in  NUM_REQ*32  Operand B; same packing as `req_a`.
- `req_cin`  in  NUM_REQ  Carry-in per requester.
- `req_wide`  in  NUM_REQ  1 = 32-bit add; 0 = 16-bit add, which uses bits [15:0] only.
- `rsp_valid`  out  1  Response valid.
- `rsp_ready`  in  1  Response accept from the consumer.
- `rsp_id`  out  ID_W  Index of the requester that was served.
- `rsp_sum`  out  32  Result. Bits [31:16] are zero for a 16-bit add.
- `rsp_cout`  out  1  Carry out of bit 15 for a 16-bit add, or of bit 31 for a 32-bit add.

## Operation
- FSM states: IDLE, LO, HI, RESP.
- **IDLE**
  - If any `req_valid` is high, the winner is the first set bit found searching upward from `rr_ptr`, wrapping around.
  - `req_ready[winner]` is driven combinationally high in the same cycle.
  - On that cycle the block latches a, b, cin, wide and id, then goes to LO.
  - `req_ready` is 0 in every state other than IDLE.
- **LO**
  - Adder inputs are a[15:0], b[15:0] and the latched cin.
  - Register sum[15:0] and the adder cout as `c16`.
  - Next state is HI if wide, otherwise RESP.
- **HI**
  - Adder inputs are a[31:16], b[31:16] and `c16`.
  - Register sum[31:16] and cout, then go to RESP.
- **RESP**
  - `rsp_valid` = 1, with `rsp_id`, `rsp_sum` and `rsp_cout` held stable until `rsp_ready`.
  - On the handshake, set `rr_ptr` ← (id+1) mod NUM_REQ and go to IDLE.
- Requesters must hold valid and operands stable until they see `req_ready`. Dropping `req_valid` before grant is legal; the request is simply not served.
- Arithmetic is modular. There are no overflow or saturation flags.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0, `req_ready`=0, `rr_ptr`=0, state = IDLE.
- Latency from grant cycle t to `rsp_valid`: t+2 for a 16-bit add, t+3 for a 32-bit add.
- Minimum issue interval with `rsp_ready` tied high: 3 cycles for 16-bit adds, 4 cycles for 32-bit adds.
- Backpressure: the block stalls in RESP indefinitely. No new grants are issued while it waits.
- When several requesters are valid at once, exactly one is granted per IDLE visit. `rr_ptr` only advances on response handshake.
- Reset asserted mid-operation: the in-flight op is discarded, no response is produced, and all outputs return to reset values immediately.
- No combinational path from `rsp_ready` to any output except the state update.
- `req_ready` depends combinationally on `req_valid` and state only.

## Structure
- Package `adder_arb_pkg` holds:
  - state enum `arb_state_t` (IDLE, LO, HI, RESP);
  - `ADD_W`=16 and `WIDE_W`=32.
- A single instance of the existing `carry_lookahead_adder` serves as the datapath. Its inputs are muxed by state: low halves in LO, high halves in HI.
- Optional sub-module `rr_picker`: a combinational round-robin first-set search from a pointer, producing a one-hot grant and a found flag.

## Test plan
- **Narrow add:** req0 sends a=0x0000_FFFF, b=0x0000_0001, cin=0, wide=0 → rsp at t+2 with id=0, sum=0x0000_0000, cout=1.
- **Wide add with carry chain:** req2 sends a=0x0001_FFFF, b=0x0000_0001, cin=1, wide=1 → rsp at t+3 with sum=0x0002_0001, cout=0.
- **Wide overflow:** a=0xFFFF_FFFF, b=0x0000_0000, cin=1, wide=1 → sum=0x0000_0000, cout=1.
- **Round-robin fairness:** all four requesters valid continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3, and `req_ready` is never more than one-hot.
- **Backpressure:** `rsp_ready`=0 for 10 cycles during RESP → response fields stay stable, `req_ready` stays 0, and the response is delivered once `rsp_ready`=1.
- **Reset mid-op:** assert `rst_n`=0 during HI → outputs reset, no response emitted. After release, a pending req1 is granted first because `rr_ptr`=0 and req0 is idle.
